bonus_ctrl: RTL and testbench

//  Sequences the falling bonus object: holds it parked at its pre-start pixel

---
 rtl/bonus_ctrl.sv | 154 +++++++++++++++
 tb/tb_bonus_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bonus_ctrl.sv
// Bonus object sequencer: park, spawn, fall, catch/miss, effect and cooldown.
// In: clk, reset, startOfFrame, spawn_req, spawnX/Y, paddle_hit, clear.
// Out: activate, topLeftMoveX/Y, visible, award, effect_active (all registered).
module bonus_ctrl #(
    parameter int FALL_SPEED      = 2,
    parameter int BOTTOM_Y        = 479,
    parameter int EFFECT_FRAMES   = 600,
    parameter int COOLDOWN_FRAMES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        spawn_req,
    input  logic [10:0] spawnX,
    input  logic [10:0] spawnY,
    input  logic        paddle_hit,
    input  logic        clear,
    output logic        activate,
    output logic [10:0] topLeftMoveX,
    output logic [10:0] topLeftMoveY,
    output logic        visible,
    output logic        award,
    output logic        effect_active
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FALLING  = 2'd1,
        ACTIVE   = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    localparam int CMAX = (EFFECT_FRAMES > COOLDOWN_FRAMES) ?
                          EFFECT_FRAMES : COOLDOWN_FRAMES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] EF_LAST = CW'(EFFECT_FRAMES - 1);
    localparam logic [CW-1:0] CF_LAST = CW'(COOLDOWN_FRAMES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [11:0]   BOT     = 12'(BOTTOM_Y);
    localparam logic [11:0]   STEP    = 12'(FALL_SPEED);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [10:0]   x_q, x_d;
    logic [10:0]   y_q, y_d;
    logic [11:0]   y_next;

    logic activate_q, activate_d;
    logic visible_q, visible_d;
    logic award_q, award_d;
    logic effect_q, effect_d;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            activate_q <= 1'b1;
            visible_q  <= 1'b0;
            award_q    <= 1'b0;
            effect_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            activate_q <= activate_d;
            visible_q  <= visible_d;
            award_q    <= award_d;
            effect_q   <= effect_d;
        end
    end

    // Next state. Y is stepped in 12 bits so a step past the
    // bottom row is detected instead of wrapping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        y_next  = {1'b0, y_q} + STEP;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (spawn_req) begin
                        state_d = FALLING;
                        x_d     = spawnX;
                        y_d     = spawnY;
                    end
                end
                FALLING: begin
                    // Catch has priority over a simultaneous miss.
                    if (paddle_hit) begin
                        state_d = ACTIVE;
                        cnt_d   = '0;
                    end else if (startOfFrame) begin
                        if (y_next > BOT) begin
                            state_d = COOLDOWN;
                            cnt_d   = '0;
                        end else begin
                            y_d = y_next[10:0];
                        end
                    end
                end
                ACTIVE: begin
                    if (startOfFrame) begin
                        if (cnt_q == EF_LAST) begin
                            state_d = COOLDOWN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                COOLDOWN: begin
                    if (startOfFrame) begin
                        if (cnt_q == CF_LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Registered outputs follow the state being entered.
    always_comb begin
        activate_d = (state_d == IDLE) || (state_d == COOLDOWN);
        visible_d  = (state_d == FALLING);
        effect_d   = (state_d == ACTIVE);
        award_d    = !clear && (state_q == FALLING) && paddle_hit;
    end

    assign activate      = activate_q;
    assign topLeftMoveX  = x_q;
    assign topLeftMoveY  = y_q;
    assign visible       = visible_q;
    assign award         = award_q;
    assign effect_active = effect_q;

endmodule

// File: tb/tb_bonus_ctrl.sv
// Directed and randomized checks of bonus_ctrl against a frame-countdown model.
// Bench parameters: FALL_SPEED=2, BOTTOM_Y=210, EFFECT_FRAMES=4, COOLDOWN_FRAMES=2.
module tb_bonus_ctrl;

    localparam int FS  = 2;
    localparam int BY  = 210;
    localparam int EFR = 4;
    localparam int CFR = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic        spawn_req = 1'b0;
    logic [10:0] spawnX = '0;
    logic [10:0] spawnY = '0;
    logic        paddle_hit = 1'b0;
    logic        clear = 1'b0;
    logic        activate;
    logic [10:0] topLeftMoveX;
    logic [10:0] topLeftMoveY;
    logic        visible;
    logic        award;
    logic        effect_active;

    int compared = 0;
    int mismatched = 0;
    int awards_seen = 0;

    // Model: phase 0 parked, 1 dropping, 2 effect, 3 cooldown.
    int          m_phase = 0;
    int          m_left = 0;
    int          m_x = 0;
    int          m_y = 0;
    bit          m_award = 0;

    bonus_ctrl #(
        .FALL_SPEED(FS),
        .BOTTOM_Y(BY),
        .EFFECT_FRAMES(EFR),
        .COOLDOWN_FRAMES(CFR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .startOfFrame(startOfFrame),
        .spawn_req(spawn_req),
        .spawnX(spawnX),
        .spawnY(spawnY),
        .paddle_hit(paddle_hit),
        .clear(clear),
        .activate(activate),
        .topLeftMoveX(topLeftMoveX),
        .topLeftMoveY(topLeftMoveY),
        .visible(visible),
        .award(award),
        .effect_active(effect_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_tick();
        m_award = 0;
        if (reset) begin
            m_phase = 0;
            m_x = 0;
            m_y = 0;
        end else if (clear) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (spawn_req) begin
                    m_phase = 1;
                    m_x = int'(spawnX);
                    m_y = int'(spawnY);
                end
                1: if (paddle_hit) begin
                    m_phase = 2;
                    m_left = EFR;
                    m_award = 1;
                end else if (startOfFrame) begin
                    if (m_y + FS > BY) begin
                        m_phase = 3;
                        m_left = CFR;
                    end else begin
                        m_y = m_y + FS;
                    end
                end
                2: if (startOfFrame) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 3;
                        m_left = CFR;
                    end
                end
                default: if (startOfFrame) begin
                    m_left--;
                    if (m_left == 0) m_phase = 0;
                end
            endcase
        end
    endtask

    task automatic check_all();
        chk("activate", int'(activate), int'(m_phase == 0 || m_phase == 3));
        chk("visible", int'(visible), int'(m_phase == 1));
        chk("effect_active", int'(effect_active), int'(m_phase == 2));
        chk("award", int'(award), int'(m_award));
        chk("moveX", int'(topLeftMoveX), m_x);
        chk("moveY", int'(topLeftMoveY), m_y);
        if (award === 1'b1) awards_seen++;
    endtask

    task automatic step(input bit r, input bit sof, input bit sp,
                        input int sx, input int sy,
                        input bit hit, input bit clr);
        reset        = r;
        startOfFrame = sof;
        spawn_req    = sp;
        spawnX       = 11'(sx);
        spawnY       = 11'(sy);
        paddle_hit   = hit;
        clear        = clr;
        @(posedge clk);
        model_tick();
        #1;
        check_all();
    endtask

    task automatic idle_cyc();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic frame();
        step(0, 1, 0, 0, 0, 0, 0);
        idle_cyc();
    endtask

    initial begin
        // 1: reset
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t1_activate", int'(activate), 1);
        chk("t1_visible", int'(visible), 0);
        chk("t1_moveY", int'(topLeftMoveY), 0);
        idle_cyc();

        // 2: spawn and fall three frames
        step(0, 0, 1, 100, 200, 0, 0);
        chk("t2_activate", int'(activate), 0);
        chk("t2_visible", int'(visible), 1);
        chk("t2_moveX", int'(topLeftMoveX), 100);
        chk("t2_moveY0", int'(topLeftMoveY), 200);
        repeat (3) frame();
        chk("t2_moveY3", int'(topLeftMoveY), 206);

        // 3: reach the bottom, miss, cool down
        awards_seen = 0;
        frame();
        frame();
        chk("t3_moveY210", int'(topLeftMoveY), 210);
        chk("t3_vis210", int'(visible), 1);
        frame();
        chk("t3_miss_vis", int'(visible), 0);
        chk("t3_miss_act", int'(activate), 1);
        chk("t3_moveYkept", int'(topLeftMoveY), 210);
        frame();
        frame();
        chk("t3_no_award", awards_seen, 0);
        step(0, 0, 1, 10, 20, 0, 0);
        chk("t3_respawn", int'(visible), 1);

        // 4: catch, effect for 4 frames, spawn ignored
        step(0, 0, 0, 0, 0, 1, 0);
        chk("t4_award", int'(award), 1);
        chk("t4_effect", int'(effect_active), 1);
        idle_cyc();
        chk("t4_award_off", int'(award), 0);
        step(0, 0, 1, 300, 100, 0, 0);
        chk("t4_spawn_ign", int'(visible), 0);
        repeat (3) frame();
        chk("t4_effect3", int'(effect_active), 1);
        frame();
        chk("t4_effect4", int'(effect_active), 0);
        repeat (2) frame();

        // 5: catch and miss step together
        step(0, 0, 1, 50, 210, 0, 0);
        step(0, 1, 0, 0, 0, 1, 0);
        chk("t5_award", int'(award), 1);
        chk("t5_effect", int'(effect_active), 1);
        repeat (6) frame();

        // 6: clear while falling, spawn in same cycle dropped
        step(0, 0, 1, 30, 200, 0, 0);
        frame();
        frame();
        chk("t6_y204", int'(topLeftMoveY), 204);
        step(0, 0, 1, 77, 77, 0, 1);
        chk("t6_activate", int'(activate), 1);
        chk("t6_visible", int'(visible), 0);
        chk("t6_moveY", int'(topLeftMoveY), 204);
        idle_cyc();
        chk("t6_still_idle", int'(visible), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 2047)),
                 int'($urandom_range(150, 215)),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
